// File: rtl/cw_datapath_pkg.sv
// Shared types and constants for the control-word datapath (package dp_pkg).
// Control word layout, MSB first:
// {RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf, aluOP}
package dp_pkg;

   localparam int CW_W = 15;
   localparam logic [2:0] REG_ZERO = 3'd0;
   localparam int CONST_ONE = 1;

   typedef enum logic [2:0] {
      ADD  = 3'b000,
      SUB  = 3'b001,
      AND  = 3'b010,
      OR   = 3'b011,
      XOR  = 3'b100,
      NOT  = 3'b101,
      SHL  = 3'b110,
      PASS = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic       rf_src_sel;
      logic [2:0] read_addr1;
      logic [2:0] read_addr2;
      logic [2:0] write_addr;
      logic       write_en;
      logic       out_buf;
      alu_op_e    alu_op;
   } ctrl_word_t;

   // Unary ops never look at operand b.
   function automatic logic is_unary(input alu_op_e op);
      return (op == NOT) || (op == SHL) || (op == PASS);
   endfunction

endpackage

// File: rtl/cw_datapath_if.sv
// Control-word bus between the control FSM (master) and the datapath (slave).
// The ovf flag exists only when DP_OVF_FLAG_EN is defined.
interface cw_datapath_if #(parameter int DATA_W = 8);

   logic              RFSrcMuxSel;
   logic [2:0]        readAddr1;
   logic [2:0]        readAddr2;
   logic [2:0]        writeAddr;
   logic              writeEn;
   logic              outBuf;
   logic [2:0]        aluOP;
   logic              aBTb;
   logic [DATA_W-1:0] outPort;
`ifdef DP_OVF_FLAG_EN
   logic              ovf;
`endif

   modport master (
      output RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf, aluOP,
`ifdef DP_OVF_FLAG_EN
      input  ovf,
`endif
      input  aBTb, outPort
   );

   modport slave (
      input  RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf, aluOP,
`ifdef DP_OVF_FLAG_EN
      output ovf,
`endif
      output aBTb, outPort
   );

endinterface

// File: rtl/cw_datapath_register_file.sv
// 8 x DATA_W register file: two combinational read ports, one synchronous
// write port. R0 is hardwired to zero; writes to it are dropped.
module register_file
   import dp_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [2:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        raddr1,
   input  logic [2:0]        raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] mem [8];

   // Storage update; entry 0 is only ever cleared, so it stays zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) mem[i] <= '0;
      end else if (we && (waddr != REG_ZERO)) begin
         mem[waddr] <= wdata;
      end
   end

   // No write bypass: a same-cycle read sees the pre-edge value.
   assign rdata1 = (raddr1 == REG_ZERO) ? '0 : mem[raddr1];
   assign rdata2 = (raddr2 == REG_ZERO) ? '0 : mem[raddr2];

endmodule

// File: rtl/cw_datapath.sv
// Control-word driven datapath: register file, ALU, output buffer, aBTb flag.
// Optional macro DP_OVF_FLAG_EN adds a sticky overflow flag (ovf).
module cw_datapath
   import dp_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   cw_datapath_if.slave  bus
);

   ctrl_word_t        cw;
   logic [DATA_W-1:0] rd_a, rd_b, a, b, alu_res, wdata;
   logic [DATA_W:0]   sum;
   logic              alu_wr, commit;

   assign cw = {bus.RFSrcMuxSel, bus.readAddr1, bus.readAddr2, bus.writeAddr,
                bus.writeEn, bus.outBuf, bus.aluOP};

   register_file #(.DATA_W(DATA_W)) u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     (cw.write_en),
      .waddr  (cw.write_addr),
      .wdata  (wdata),
      .raddr1 (cw.read_addr1),
      .raddr2 (cw.read_addr2),
      .rdata1 (rd_a),
      .rdata2 (rd_b)
   );

   // Operand b is forced to zero for unary ops so an undriven readAddr2
   // cannot leak into the result or the a>b compare.
   assign a   = rd_a;
   assign b   = is_unary(cw.alu_op) ? '0 : rd_b;
   assign sum = {1'b0, a} + {1'b0, b};

   // ALU, unsigned with wrap-around.
   always_comb begin
      alu_res = '0;
      case (cw.alu_op)
         ADD:     alu_res = sum[DATA_W-1:0];
         SUB:     alu_res = a - b;
         AND:     alu_res = a & b;
         OR:      alu_res = a | b;
         XOR:     alu_res = a ^ b;
         NOT:     alu_res = ~a;
         SHL:     alu_res = {a[DATA_W-2:0], 1'b0};
         PASS:    alu_res = a;
         default: alu_res = a;
      endcase
   end

   assign wdata  = cw.rf_src_sel ? DATA_W'(CONST_ONE) : alu_res;
   assign alu_wr = cw.write_en && !cw.rf_src_sel;
   assign commit = alu_wr && (cw.write_addr != REG_ZERO);

   // Output buffer and compare flag; the flag also updates on R0 writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.outPort <= '0;
         bus.aBTb    <= 1'b0;
      end else begin
         if (cw.out_buf) bus.outPort <= alu_res;
         if (alu_wr)     bus.aBTb    <= (a > b);
      end
   end

`ifdef DP_OVF_FLAG_EN
   logic ovf_evt;
   assign ovf_evt = ((cw.alu_op == ADD) && sum[DATA_W]) ||
                    ((cw.alu_op == SUB) && (a < b))     ||
                    ((cw.alu_op == SHL) && a[DATA_W-1]);

   // Sticky overflow, set only by committed ALU writes, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset)                  bus.ovf <= 1'b0;
      else if (commit && ovf_evt) bus.ovf <= 1'b1;
   end
`else
   logic unused_commit;
   assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_cw_datapath.sv
// Self-checking bench for cw_datapath: directed scenarios plus random control
// words checked against an arithmetic reference model.
module tb_cw_datapath;
   import dp_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   cw_datapath_if #(.DATA_W(8)) bus ();

   cw_datapath #(.DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Reference state
   int m_rf [8];
   int m_out, m_abtb, m_ovf;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
      m_out = 0; m_abtb = 0; m_ovf = 0;
   endtask

   // Apply one control word for one clock and advance the model.
   task automatic apply(input logic src, input int ra1, input int ra2, input int wa,
                        input logic we, input logic ob, input int op, input logic xb = 1'b0);
      int a, b, res, raw;
      @(negedge clk);
      bus.RFSrcMuxSel = src;
      bus.readAddr1   = 3'(ra1);
      bus.readAddr2   = xb ? 3'bxxx : 3'(ra2);
      bus.writeAddr   = 3'(wa);
      bus.writeEn     = we;
      bus.outBuf      = ob;
      bus.aluOP       = 3'(op);
      a = m_rf[ra1];
      b = (op >= 5) ? 0 : m_rf[ra2];
      case (op)
         0: raw = a + b;
         1: raw = a - b;
         2: raw = a & b;
         3: raw = a | b;
         4: raw = a ^ b;
         5: raw = 255 - a;
         6: raw = a * 2;
         default: raw = a;
      endcase
      res = ((raw % 256) + 256) % 256;
      @(posedge clk);
      if (we && !src && wa != 0 &&
          ((op == 0 && raw > 255) || (op == 1 && raw < 0) || (op == 6 && raw > 255)))
         m_ovf = 1;
      if (we && !src) m_abtb = (a > b) ? 1 : 0;
      if (ob) m_out = res;
      if (we && wa != 0) m_rf[wa] = src ? 1 : res;
      #1;
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".outPort"}, bus.outPort, 8'(m_out));
      check({tag, ".aBTb"}, {7'd0, bus.aBTb}, 8'(m_abtb));
`ifdef DP_OVF_FLAG_EN
      check({tag, ".ovf"}, {7'd0, bus.ovf}, 8'(m_ovf));
`endif
   endtask

   // Observe a register through the PASS op into outPort.
   task automatic read_reg(input string tag, input int n);
      apply(1'b0, n, 0, 0, 1'b0, 1'b1, 7);
      check($sformatf("%s.R%0d", tag, n), bus.outPort, 8'(m_rf[n]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.writeEn = 1'b1; bus.outBuf = 1'b1; bus.RFSrcMuxSel = 1'b1; bus.writeAddr = 3'd2;
      @(posedge clk);
      model_reset();
      #1;
      @(negedge clk);
      reset = 1'b0;
      bus.writeEn = 1'b0; bus.outBuf = 1'b0; bus.RFSrcMuxSel = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.RFSrcMuxSel = 0; bus.readAddr1 = 0; bus.readAddr2 = 0; bus.writeAddr = 0;
      bus.writeEn = 0; bus.outBuf = 0; bus.aluOP = 0;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();
      #1;
      check_outs("reset");
      for (int i = 1; i < 8; i++) read_reg("reset", i);

      // R3 = 1 (constant), R4 = R3 + R3 with outBuf
      apply(1'b1, 0, 0, 3, 1'b1, 1'b0, 0);
      apply(1'b0, 3, 3, 4, 1'b1, 1'b1, 0);
      check("t2.outPort", bus.outPort, 8'd2);
      read_reg("t2", 4);

      // Mid-run reset with R3 loaded
      do_reset();
      #1;
      check_outs("t1");
      check("t1.outPort0", bus.outPort, 8'd0);
      read_reg("t1", 3);

      // SUB wrap: R5 = R1 - R3 = 0 - 1
      apply(1'b1, 0, 0, 3, 1'b1, 1'b0, 0);
      apply(1'b0, 3, 3, 4, 1'b1, 1'b0, 0);
      apply(1'b0, 1, 3, 5, 1'b1, 1'b0, 1);
      check("t3.aBTb", {7'd0, bus.aBTb}, 8'd0);
`ifdef DP_OVF_FLAG_EN
      check("t3.ovf", {7'd0, bus.ovf}, 8'd1);
`endif
      read_reg("t3", 5);
      check("t3.R5ff", bus.outPort, 8'hFF);

      // Compare via R0 write: no register side effect, outPort held
      apply(1'b0, 4, 3, 0, 1'b1, 1'b0, 0);
      check("t4.aBTb", {7'd0, bus.aBTb}, 8'd1);
      check_outs("t4");
      read_reg("t4", 0);

      // Build R7 = 0x0F, then NOT with readAddr2 undriven
      apply(1'b1, 0, 0, 6, 1'b1, 1'b0, 0);
      apply(1'b0, 6, 6, 7, 1'b1, 1'b0, 0);
      repeat (3) apply(1'b0, 7, 7, 7, 1'b1, 1'b0, 0);
      apply(1'b0, 7, 6, 7, 1'b1, 1'b0, 1);
      read_reg("t5pre", 7);
      apply(1'b0, 7, 0, 7, 1'b1, 1'b1, 5, 1'b1);
      check("t5.outPort", bus.outPort, 8'hF0);
      check("t5.known", {7'd0, $isunknown({bus.outPort, bus.aBTb})}, 8'd0);
      check_outs("t5");
      read_reg("t5", 7);

      // Halt word held for 10 cycles
      apply(1'b0, 4, 3, 0, 1'b1, 1'b1, 0);
      repeat (10) apply(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
      check_outs("t6");
      for (int i = 1; i < 8; i++) read_reg("t6", i);

      // Random control words
      for (int n = 0; n < 300; n++) begin
         apply(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
         check_outs("rand");
      end
      for (int i = 0; i < 8; i++) read_reg("final", i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
